// File: rtl/pwm_motor_bank.sv
// Multi-channel motor PWM: one shared period counter, per-channel duties,
// double-buffered updates applied at period boundaries, and a failsafe watchdog.
module pwm_motor_bank #(
    parameter int NCH        = 4,
    parameter int W          = 24,
    parameter int FS_PERIODS = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     period,
    input  logic [NCH*W-1:0] duty,
    input  logic             load,
    input  logic [NCH-1:0]   ch_en,
    input  logic             arm,
    output logic [NCH-1:0]   pwm_out,
    output logic             period_start,
    output logic             failsafe
);

    localparam int FSW = (FS_PERIODS > 0) ? $clog2(FS_PERIODS + 1) : 1;
    localparam logic [FSW-1:0] FS_MAX = FSW'(FS_PERIODS);

    function automatic logic [W-1:0] clamp_duty(input logic [W-1:0] d, input logic [W-1:0] p);
        clamp_duty = (d > p) ? p : d;
    endfunction

    logic [W-1:0]     counter_r;
    logic [W-1:0]     per_pend_r;
    logic [W-1:0]     per_act_r;
    logic [NCH*W-1:0] duty_pend_r;
    logic [NCH*W-1:0] duty_act_r;
    logic [NCH-1:0]   en_pend_r;
    logic [NCH-1:0]   en_act_r;
    logic [FSW-1:0]   fs_cnt_r;
    logic             failsafe_r;
    logic             block_r;
    logic             period_start_r;
    logic [NCH-1:0]   pwm_r;

    logic             run_s;
    logic             boundary_s;
    logic             trip_s;
    logic [W-1:0]     counter_next_s;
    logic [W-1:0]     src_per_s;
    logic [NCH*W-1:0] src_duty_s;
    logic [NCH-1:0]   src_en_s;
    logic [NCH*W-1:0] xfer_duty_s;
    logic [NCH-1:0]   pwm_next_s;
    logic [FSW-1:0]   fs_cnt_next_s;

    // Boundary detection, transfer source selection and next-state decode
    always_comb begin
        run_s          = (per_act_r != {W{1'b0}});
        boundary_s     = !run_s || (counter_r == (per_act_r - W'(1)));
        trip_s         = 1'b0;
        counter_next_s = {W{1'b0}};
        src_per_s      = per_pend_r;
        src_duty_s     = duty_pend_r;
        src_en_s       = en_pend_r;
        xfer_duty_s    = {(NCH*W){1'b0}};
        pwm_next_s     = {NCH{1'b0}};
        fs_cnt_next_s  = fs_cnt_r;

        if (FS_PERIODS > 0) begin
            trip_s = (fs_cnt_r == FS_MAX);
        end else begin
            trip_s = 1'b0;
        end

        if (boundary_s) begin
            counter_next_s = {W{1'b0}};
        end else begin
            counter_next_s = counter_r + W'(1);
        end

        // A load coinciding with a boundary bypasses the pending registers
        if (load) begin
            src_per_s  = period;
            src_duty_s = duty;
            src_en_s   = ch_en;
        end else begin
            src_per_s  = per_pend_r;
            src_duty_s = duty_pend_r;
            src_en_s   = en_pend_r;
        end

        for (int i = 0; i < NCH; i++) begin
            xfer_duty_s[i*W +: W] = clamp_duty(src_duty_s[i*W +: W], src_per_s);
            pwm_next_s[i] = arm & ~trip_s & ~block_r & en_act_r[i] & run_s &
                            (counter_r < duty_act_r[i*W +: W]);
        end

        if (load) begin
            fs_cnt_next_s = {FSW{1'b0}};
        end else if ((FS_PERIODS > 0) && boundary_s && run_s && (fs_cnt_r != FS_MAX)) begin
            fs_cnt_next_s = fs_cnt_r + FSW'(1);
        end else begin
            fs_cnt_next_s = fs_cnt_r;
        end
    end

    // Pending and active parameter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            per_pend_r  <= {W{1'b0}};
            duty_pend_r <= {(NCH*W){1'b0}};
            en_pend_r   <= {NCH{1'b0}};
            per_act_r   <= {W{1'b0}};
            duty_act_r  <= {(NCH*W){1'b0}};
            en_act_r    <= {NCH{1'b0}};
        end else begin
            if (load) begin
                per_pend_r  <= period;
                duty_pend_r <= duty;
                en_pend_r   <= ch_en;
            end
            if (boundary_s) begin
                per_act_r  <= src_per_s;
                duty_act_r <= xfer_duty_s;
                en_act_r   <= src_en_s;
            end
        end
    end

    // Counter, watchdog and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_r      <= {W{1'b0}};
            fs_cnt_r       <= {FSW{1'b0}};
            failsafe_r     <= 1'b0;
            block_r        <= 1'b0;
            period_start_r <= 1'b0;
            pwm_r          <= {NCH{1'b0}};
        end else begin
            counter_r      <= counter_next_s;
            fs_cnt_r       <= fs_cnt_next_s;
            failsafe_r     <= trip_s & ~load;
            period_start_r <= boundary_s & run_s;
            pwm_r          <= pwm_next_s;
            // Outputs stay muted after a trip until the boundary following the clearing load
            if (trip_s) begin
                block_r <= 1'b1;
            end else if (boundary_s) begin
                block_r <= 1'b0;
            end
        end
    end

    assign pwm_out      = pwm_r;
    assign period_start = period_start_r;
    assign failsafe     = failsafe_r;

endmodule

// File: tb/tb_pwm_motor_bank.sv
// Bench for pwm_motor_bank: table of per-period high-time vectors, hand-written
// corner sequences, and randomized stimulus against a reference model.
module tb_pwm_motor_bank;

    localparam int NCH = 4;
    localparam int W   = 12;
    localparam int FS  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     period;
    logic [NCH*W-1:0] duty;
    logic             load;
    logic [NCH-1:0]   ch_en;
    logic             arm;
    logic [NCH-1:0]   pwm_out;
    logic             period_start;
    logic             failsafe;

    pwm_motor_bank #(.NCH(NCH), .W(W), .FS_PERIODS(FS)) dut (
        .clk          (clk),
        .reset        (reset),
        .period       (period),
        .duty         (duty),
        .load         (load),
        .ch_en        (ch_en),
        .arm          (arm),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .failsafe     (failsafe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [W-1:0]     per;
        logic [NCH*W-1:0] d;
        logic [NCH-1:0]   en;
        logic             arm;
        logic [NCH*W-1:0] hi;
    } vec_t;

    vec_t tbl [6];

    // Reference model state: active/pending settings, position in period, watchdog
    bit             model_on = 1'b0;
    int             m_per, m_pos, m_pend_per, m_since_load;
    int             m_duty [NCH];
    int             m_pend_duty [NCH];
    logic [NCH-1:0] m_en, m_pend_en;
    bit             m_muted;
    logic [NCH-1:0] e_pwm;
    bit             e_ps, e_fs;

    function automatic logic [NCH*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    function automatic vec_t mk(input int per, input logic [NCH*W-1:0] d, input logic [NCH-1:0] en,
                                input logic a, input logic [NCH*W-1:0] hi);
        vec_t v;
        v.per = W'(per);
        v.d   = d;
        v.en  = en;
        v.arm = a;
        v.hi  = hi;
        return v;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clock();
        bit bnd, tripped;
        if (!reset) begin
            m_per = 0; m_pos = 0; m_pend_per = 0; m_since_load = 0;
            m_en = '0; m_pend_en = '0; m_muted = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_duty[i] = 0;
                m_pend_duty[i] = 0;
            end
            e_pwm = '0; e_ps = 1'b0; e_fs = 1'b0;
            return;
        end
        tripped = (FS > 0) && (m_since_load >= FS);
        bnd     = (m_per == 0) || (m_pos == m_per - 1);
        for (int i = 0; i < NCH; i++)
            e_pwm[i] = arm && !tripped && !m_muted && m_en[i] && (m_per != 0) && (m_pos < m_duty[i]);
        e_ps = bnd && (m_per != 0);
        e_fs = tripped && !load;
        if (tripped) m_muted = 1'b1;
        else if (bnd) m_muted = 1'b0;
        if (load) m_since_load = 0;
        else if (bnd && m_per != 0 && m_since_load < FS) m_since_load++;
        m_pos = bnd ? 0 : m_pos + 1;
        if (bnd) begin
            if (load) begin
                m_per = int'(period);
                m_en  = ch_en;
                for (int i = 0; i < NCH; i++) m_duty[i] = imin(int'(duty[i*W +: W]), m_per);
            end else begin
                m_per = m_pend_per;
                m_en  = m_pend_en;
                for (int i = 0; i < NCH; i++) m_duty[i] = imin(m_pend_duty[i], m_per);
            end
        end
        if (load) begin
            m_pend_per = int'(period);
            m_pend_en  = ch_en;
            for (int i = 0; i < NCH; i++) m_pend_duty[i] = int'(duty[i*W +: W]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (model_on) model_clock();
        #1;
        if (model_on) begin
            check("rnd_pwm", 32'(pwm_out), 32'(e_pwm));
            check("rnd_ps", 32'(period_start), 32'(e_ps));
            check("rnd_fs", 32'(failsafe), 32'(e_fs));
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        load  = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic do_load(input int per, input logic [NCH*W-1:0] d, input logic [NCH-1:0] en, input logic a);
        period = W'(per);
        duty   = d;
        ch_en  = en;
        arm    = a;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic wait_ps(input int bound);
        int k;
        step();
        k = 1;
        while (period_start !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        check("ps_wait", 32'(period_start), 32'd1);
    endtask

    initial begin
        int cnt [NCH];
        int hi, rises, ps_cnt, leak;
        logic prev;

        reset = 1'b0; load = 1'b0; arm = 1'b0;
        period = '0; duty = '0; ch_en = '0;

        tbl[0] = mk(100, pack4(10, 50, 0, 100), 4'hF, 1'b1, pack4(10, 50, 0, 100));
        tbl[1] = mk(100, pack4(150, 1, 99, 30), 4'hF, 1'b1, pack4(100, 1, 99, 30));
        tbl[2] = mk(37, pack4(5, 36, 37, 0), 4'b1010, 1'b1, pack4(0, 36, 0, 0));
        tbl[3] = mk(20, pack4(20, 19, 1, 7), 4'hF, 1'b0, pack4(0, 0, 0, 0));
        tbl[4] = mk(64, pack4(63, 64, 2, 33), 4'b0111, 1'b1, pack4(63, 64, 2, 0));
        tbl[5] = mk(1, pack4(1, 0, 1, 5), 4'hF, 1'b1, pack4(1, 0, 1, 1));

        apply_reset();
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        check("reset_fs", 32'(failsafe), 32'd0);

        // Table: high clocks per channel over one full period after the transfer
        for (int v = 0; v < 6; v++) begin
            do_load(int'(tbl[v].per), tbl[v].d, tbl[v].en, tbl[v].arm);
            wait_ps(300);
            for (int c = 0; c < NCH; c++) cnt[c] = 0;
            for (int k = 0; k < int'(tbl[v].per); k++) begin
                step();
                for (int c = 0; c < NCH; c++) if (pwm_out[c]) cnt[c]++;
            end
            for (int c = 0; c < NCH; c++)
                check($sformatf("tbl%0d_ch%0d_high", v, c), 32'(cnt[c]), 32'(tbl[v].hi[c*W +: W]));
        end
        arm = 1'b1;

        // Mid-period duty change: current period keeps old duty, next uses new
        apply_reset();
        do_load(100, pack4(10, 0, 0, 0), 4'h1, 1'b1);
        wait_ps(300);
        for (int w = 0; w < 2; w++) begin
            hi = 0; rises = 0; prev = pwm_out[0];
            for (int k = 1; k <= 100; k++) begin
                step();
                if (pwm_out[0]) hi++;
                if (pwm_out[0] && !prev) rises++;
                prev = pwm_out[0];
                if (w == 0 && k == 40) begin
                    duty = pack4(80, 0, 0, 0);
                    load = 1'b1;
                end else begin
                    load = 1'b0;
                end
            end
            check($sformatf("midload_w%0d_high", w), 32'(hi), (w == 0) ? 32'd10 : 32'd80);
            check($sformatf("midload_w%0d_rises", w), 32'(rises), 32'd1);
            check($sformatf("midload_w%0d_ps", w), 32'(period_start), 32'd1);
        end

        // Load exactly at the boundary (counter == 99)
        for (int k = 0; k < 99; k++) step();
        duty = pack4(5, 0, 0, 0);
        load = 1'b1;
        step();
        load = 1'b0;
        check("bndload_ps", 32'(period_start), 32'd1);
        hi = 0; ps_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (pwm_out[0]) hi++;
            if (period_start) ps_cnt++;
        end
        check("bndload_high", 32'(hi), 32'd5);
        check("bndload_ps_count", 32'(ps_cnt), 32'd1);
        check("bndload_fs", 32'(failsafe), 32'd0);

        // Zero period: outputs low, no period_start
        do_load(0, pack4(5, 5, 5, 5), 4'hF, 1'b1);
        for (int k = 0; k < 110; k++) step();
        leak = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (pwm_out != '0 || period_start) leak++;
        end
        check("zero_period_quiet", 32'(leak), 32'd0);

        // Watchdog: trips after 3 unrefreshed boundaries, load rearms at next boundary
        apply_reset();
        do_load(20, pack4(10, 5, 0, 20), 4'hF, 1'b1);
        for (int p = 0; p < 3; p++) wait_ps(100);
        check("fs_before_trip", 32'(failsafe), 32'd0);
        check("fs_pwm_before_trip", 32'(pwm_out), 32'h8);
        step();
        check("fs_tripped", 32'(failsafe), 32'd1);
        check("fs_pwm_tripped", 32'(pwm_out), 32'd0);
        leak = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (pwm_out != '0) leak++;
        end
        load = 1'b1;
        step();
        load = 1'b0;
        check("fs_cleared", 32'(failsafe), 32'd0);
        if (pwm_out != '0) leak++;
        step();
        if (pwm_out != '0) leak++;
        while (period_start !== 1'b1 && leak < 100) begin
            step();
            if (pwm_out != '0) leak++;
            if (period_start !== 1'b1) leak += 0;
        end
        check("fs_rearm_ps", 32'(period_start), 32'd1);
        check("fs_muted_until_boundary", 32'(leak), 32'd0);
        step();
        check("fs_resumed", 32'(pwm_out), 32'hB);

        // Reset mid-period and arm toggle
        apply_reset();
        do_load(100, pack4(10, 50, 0, 100), 4'hF, 1'b1);
        wait_ps(300);
        for (int k = 0; k < 30; k++) step();
        check("midrst_pre", 32'(pwm_out), 32'hA);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrst_pwm", 32'(pwm_out), 32'd0);
        check("midrst_fs", 32'(failsafe), 32'd0);
        leak = 0;
        for (int k = 0; k < 250; k++) begin
            step();
            if (pwm_out != '0 || period_start) leak++;
        end
        check("midrst_quiet", 32'(leak), 32'd0);
        do_load(100, pack4(10, 50, 0, 100), 4'hF, 1'b1);
        wait_ps(300);
        for (int k = 0; k < 5; k++) step();
        check("arm_on", 32'(pwm_out), 32'hB);
        arm = 1'b0;
        step();
        check("arm_off", 32'(pwm_out), 32'd0);
        step();
        step();
        arm = 1'b1;
        step();
        check("arm_back", 32'(pwm_out), 32'hB);

        // Randomized run against the reference model
        model_on = 1'b1;
        reset = 1'b0;
        load  = 1'b0;
        step();
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 299) != 0);
            load   = ((c % 500) < 350) && ($urandom_range(0, 7) == 0);
            period = W'($urandom_range(0, 12));
            for (int i = 0; i < NCH; i++) duty[i*W +: W] = W'($urandom_range(0, 15));
            ch_en  = NCH'($urandom);
            arm    = ($urandom_range(0, 15) != 0);
            step();
        end
        model_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
